// File: rtl/reg_scoreboard.sv
// Register-interlock scoreboard for the decode stage.
// Keeps one pending-write counter per architectural GPR. Decode issue increments,
// writeback commit decrements, and decode stalls while any read source still has a
// write in flight. Register 0 is never tracked. A sticky err flags counter
// overflow/underflow.
// Optional feature: define SB_WB_BYPASS_EN to let a source whose last pending write
// is retiring this cycle proceed, with the WB data forwarded by decode.
module reg_scoreboard #(
    parameter int unsigned CNT_W = 2,
    parameter int unsigned NREG  = 32
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       issue_fire_i,
    input  logic       issue_we_i,
    input  logic [4:0] issue_dest_i,
    input  logic       src1_re_i,
    input  logic [4:0] src1_addr_i,
    input  logic       src2_re_i,
    input  logic [4:0] src2_addr_i,
    input  logic       retire_we_i,
    input  logic [4:0] retire_addr_i,
    input  logic       flush_i,
    output logic       stall_o,
    output logic       busy_o,
`ifdef SB_WB_BYPASS_EN
    output logic       src1_wb_fwd_o,
    output logic       src2_wb_fwd_o,
`endif
    output logic       err_o
);

    localparam logic [CNT_W-1:0] CntMax = '1;
    localparam logic [CNT_W-1:0] CntOne = CNT_W'(1);

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             err_q;
    logic             err_d;
    logic [NREG-1:0]  inc_vec;
    logic [NREG-1:0]  dec_vec;
    logic             src1_pend;
    logic             src2_pend;

    // Per-register issue/retire strobes; r0 is left out on both sides.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int r = 1; r < NREG; r++) begin
            inc_vec[r] = issue_fire_i & issue_we_i & (issue_dest_i == 5'(r));
            dec_vec[r] = retire_we_i & (retire_addr_i == 5'(r));
        end
    end

    // Counter next state: flush wins and drops same-cycle events; saturate and flag err.
    always_comb begin
        err_d = err_q;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
        end
        if (flush_i) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_d[r] = '0;
            end
        end else begin
            for (int r = 1; r < NREG; r++) begin
                if (inc_vec[r] && !dec_vec[r]) begin
                    if (cnt_q[r] == CntMax) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] + CntOne;
                    end
                end else if (dec_vec[r] && !inc_vec[r]) begin
                    if (cnt_q[r] == '0) begin
                        err_d = 1'b1;
                    end else begin
                        cnt_d[r] = cnt_q[r] - CntOne;
                    end
                end
            end
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
            end
            err_q <= 1'b0;
        end else begin
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= cnt_d[r];
            end
            err_q <= err_d;
        end
    end

    // Source hazard: a read of a non-zero register with writes still pending.
    always_comb begin
        src1_pend = src1_re_i & (src1_addr_i != 5'd0) & (cnt_q[src1_addr_i] != '0);
        src2_pend = src2_re_i & (src2_addr_i != 5'd0) & (cnt_q[src2_addr_i] != '0);
    end

`ifdef SB_WB_BYPASS_EN
    // Last pending write retiring now: decode takes WB data instead of stalling.
    always_comb begin
        src1_wb_fwd_o = retire_we_i & (retire_addr_i == src1_addr_i) &
                        (src1_addr_i != 5'd0) & (cnt_q[src1_addr_i] == CntOne);
        src2_wb_fwd_o = retire_we_i & (retire_addr_i == src2_addr_i) &
                        (src2_addr_i != 5'd0) & (cnt_q[src2_addr_i] == CntOne);
        stall_o       = (src1_pend & ~src1_wb_fwd_o) | (src2_pend & ~src2_wb_fwd_o);
    end
`else
    // Stall depends only on counters and source fields, never on issue or retire.
    always_comb begin
        stall_o = src1_pend | src2_pend;
    end
`endif

    // Busy when any register has a pending write.
    always_comb begin
        busy_o = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy_o = busy_o | (cnt_q[r] != '0);
        end
    end

    assign err_o = err_q;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed testbench for reg_scoreboard; inputs change 1 time unit after posedge,
// outputs are checked 1 time unit later.
module tb_reg_scoreboard;

    logic       clk;
    logic       resetn;
    logic       issue_fire;
    logic       issue_we;
    logic [4:0] issue_dest;
    logic       src1_re;
    logic [4:0] src1_addr;
    logic       src2_re;
    logic [4:0] src2_addr;
    logic       retire_we;
    logic [4:0] retire_addr;
    logic       flush;
    logic       stall;
    logic       busy;
    logic       err;
`ifdef SB_WB_BYPASS_EN
    logic       src1_wb_fwd;
    logic       src2_wb_fwd;
`endif

    int checks = 0;
    int errors = 0;

    reg_scoreboard #(
        .CNT_W(2),
        .NREG (32)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .issue_fire_i (issue_fire),
        .issue_we_i   (issue_we),
        .issue_dest_i (issue_dest),
        .src1_re_i    (src1_re),
        .src1_addr_i  (src1_addr),
        .src2_re_i    (src2_re),
        .src2_addr_i  (src2_addr),
        .retire_we_i  (retire_we),
        .retire_addr_i(retire_addr),
        .flush_i      (flush),
        .stall_o      (stall),
        .busy_o       (busy),
`ifdef SB_WB_BYPASS_EN
        .src1_wb_fwd_o(src1_wb_fwd),
        .src2_wb_fwd_o(src2_wb_fwd),
`endif
        .err_o        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next posedge, leaving time before the following one.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        issue_fire  = 1'b0;
        issue_we    = 1'b0;
        issue_dest  = 5'd0;
        src1_re     = 1'b0;
        src1_addr   = 5'd0;
        src2_re     = 1'b0;
        src2_addr   = 5'd0;
        retire_we   = 1'b0;
        retire_addr = 5'd0;
        flush       = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        resetn = 1'b0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic issue(input logic [4:0] dest);
        issue_fire = 1'b1;
        issue_we   = 1'b1;
        issue_dest = dest;
        tick();
        issue_fire = 1'b0;
        issue_we   = 1'b0;
    endtask

    task automatic retire(input logic [4:0] addr);
        retire_we   = 1'b1;
        retire_addr = addr;
        tick();
        retire_we   = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        for (int i = 0; i < 2; i++) begin
            issue_fire  = 1'($urandom);
            issue_we    = 1'($urandom);
            issue_dest  = 5'($urandom);
            src1_re     = 1'($urandom);
            src1_addr   = 5'($urandom);
            src2_re     = 1'($urandom);
            src2_addr   = 5'($urandom);
            retire_we   = 1'($urandom);
            retire_addr = 5'($urandom);
            flush       = 1'($urandom);
            tick();
        end
        idle_inputs();
        resetn = 1'b1;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_stall: got %b expected 0", stall);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b expected 0", busy);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL reset_err: got %b expected 0", err);
        end
        src1_re   = 1'b1;
        src1_addr = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL reset_src5_stall: got %b expected 0", stall);
        end
        idle_inputs();
    endtask

    task automatic test_single_raw();
        do_reset();
        // Cycle 0: issue dest=5 while reading r5 (counter still 0).
        issue_fire = 1'b1;
        issue_we   = 1'b1;
        issue_dest = 5'd5;
        src1_re    = 1'b1;
        src1_addr  = 5'd5;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_c0_stall: got %b expected 0", stall);
        end
        tick();
        issue_fire = 1'b0;
        issue_we   = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            #1;
            checks++;
            if (stall !== 1'b1) begin
                errors++; $display("FAIL raw_c%0d_stall: got %b expected 1", c, stall);
            end
            tick();
        end
        // Cycle 3: writeback of r5 commits at the end of this cycle.
        retire_we   = 1'b1;
        retire_addr = 5'd5;
        #1;
`ifdef SB_WB_BYPASS_EN
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_c3_bypass_stall: got %b expected 0", stall);
        end
        checks++;
        if (src1_wb_fwd !== 1'b1) begin
            errors++; $display("FAIL raw_c3_fwd: got %b expected 1", src1_wb_fwd);
        end
`else
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL raw_c3_stall: got %b expected 1", stall);
        end
`endif
        tick();
        retire_we = 1'b0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_c4_stall: got %b expected 0", stall);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL raw_c4_busy: got %b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_r0_nonwriter();
        do_reset();
        issue(5'd0);
        issue_fire = 1'b1;
        issue_we   = 1'b0;
        issue_dest = 5'd7;
        tick();
        idle_inputs();
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL r0_busy: got %b expected 0", busy);
        end
        src2_re   = 1'b1;
        src2_addr = 5'd0;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL r0_src0_stall: got %b expected 0", stall);
        end
        src2_addr = 5'd7;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL r0_src7_stall: got %b expected 0", stall);
        end
        // Retiring r0 must neither count nor flag underflow.
        retire(5'd0);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL r0_retire_err: got %b expected 0", err);
        end
        idle_inputs();
    endtask

    task automatic test_double_write();
        do_reset();
        src1_re   = 1'b1;
        src1_addr = 5'd9;
        issue(5'd9);
        issue(5'd9);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL dbl_cnt2_stall: got %b expected 1", stall);
        end
        // Same-cycle issue and retire of r9: count holds at 2.
        issue_fire  = 1'b1;
        issue_we    = 1'b1;
        issue_dest  = 5'd9;
        retire_we   = 1'b1;
        retire_addr = 5'd9;
        tick();
        issue_fire = 1'b0;
        issue_we   = 1'b0;
        retire_we  = 1'b0;
        retire(5'd9);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL dbl_after_1st_retire_stall: got %b expected 1", stall);
        end
        retire(5'd9);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL dbl_after_2nd_retire_stall: got %b expected 0", stall);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL dbl_busy: got %b expected 0", busy);
        end
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL dbl_err: got %b expected 0", err);
        end
        idle_inputs();
    endtask

    task automatic test_overflow_underflow();
        do_reset();
        src1_re   = 1'b1;
        src1_addr = 5'd3;
        for (int i = 0; i < 3; i++) issue(5'd3);
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL ovf_3rd_err: got %b expected 0", err);
        end
        issue(5'd3);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL ovf_4th_err: got %b expected 1", err);
        end
        // Counter saturated at 3: two retires leave it pending, the third clears it.
        retire(5'd3);
        retire(5'd3);
        #1;
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL ovf_sat_stall: got %b expected 1", stall);
        end
        retire(5'd3);
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL ovf_drain_stall: got %b expected 0", stall);
        end
        do_reset();
        #1;
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL unf_pre_err: got %b expected 0", err);
        end
        retire(5'd3);
        #1;
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL unf_err: got %b expected 1", err);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL unf_busy: got %b expected 0", busy);
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        do_reset();
        retire(5'd1);  // underflow sets err, which flush must keep
        issue(5'd4);
        issue(5'd4);
        issue(5'd6);
        src1_re   = 1'b1;
        src1_addr = 5'd4;
        src2_re   = 1'b1;
        src2_addr = 5'd6;
        #1;
        checks++;
        if (busy !== 1'b1 || stall !== 1'b1) begin
            errors++;
            $display("FAIL flush_pre busy/stall: got %b/%b expected 1/1", busy, stall);
        end
        flush      = 1'b1;
        issue_fire = 1'b1;
        issue_we   = 1'b1;
        issue_dest = 5'd8;
        tick();
        flush      = 1'b0;
        issue_fire = 1'b0;
        issue_we   = 1'b0;
        #1;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL flush_busy: got %b expected 0", busy);
        end
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall_4_6: got %b expected 0", stall);
        end
        src1_addr = 5'd8;
        #1;
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL flush_stall_8: got %b expected 0", stall);
        end
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL flush_err_kept: got %b expected 1", err);
        end
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        resetn = 1'b0;
        test_reset();
        test_single_raw();
        test_r0_nonwriter();
        test_double_write();
        test_overflow_underflow();
        test_flush();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Register-interlock controller for the 5-stage pipeline; sits beside the decode stage.
- Tracks in-flight writes to each architectural GPR: counts up when decode issues a writing instruction, counts down when writeback commits the write.
- Produces the decode-stage stall, so decode's ready_go = ~stall; a RAW-dependent instruction is held in decode until its sources are committed to the regfile.
- Also provides a flush hook for future exception/cancel support.

Parameters:
- CNT_W, 2, width of each per-register pending counter; maximum in-flight writes per register = 2^CNT_W-1.
- NREG, 32, number of architectural registers; register 0 is never tracked.

Ports:
- clk  in  1  clock.
- resetn  in  1  reset, synchronous, active-low.
- issue_fire  in  1  decode handshake fired this cycle (decode valid & ready_go & execute allow_in).
- issue_we  in  1  issuing instruction writes a GPR (gr_we).
- issue_dest  in  5  destination register of issuing instruction.
- src1_re  in  1  decode instruction reads src1.
- src1_addr  in  5  src1 register (rj).
- src2_re  in  1  decode instruction reads src2.
- src2_addr  in  5  src2 register (rk or rd).
- retire_we  in  1  writeback regfile write enable this cycle.
- retire_addr  in  5  writeback regfile write address.
- flush  in  1  clear all pending state (pipeline cancel).
- stall  out  1  decode must not advance.
- busy  out  1  at least one counter non-zero.
- err  out  1  sticky overflow/underflow flag.

Behaviour:
- Reset (resetn=0 at posedge): all counters 0, err=0. As a result stall=0 and busy=0 from the first cycle after reset.
- inc[r] = issue_fire & issue_we & (issue_dest==r) & (r!=0).
- dec[r] = retire_we & (retire_addr==r) & (r!=0).
- Counter update at each posedge:
  - inc & ~dec: +1
  - dec & ~inc: -1
  - both or neither: hold
- Writes to r0 are ignored on both the issue and retire sides.
- Overflow: inc & ~dec with cnt==2^CNT_W-1 -> counter holds at max, err<=1.
- Underflow: dec & ~inc with cnt==0 -> counter holds at 0, err<=1.
- err clears only on reset; flush does not clear it.
- flush=1: all counters <= 0 next cycle. flush has priority over same-cycle inc/dec, and those events are not counted.
- stall (combinational from counter registers and src inputs only):
  - (src1_re & src1_addr!=0 & cnt[src1_addr]!=0) | (src2_re & src2_addr!=0 & cnt[src2_addr]!=0).
  - stall must not depend on issue_fire, retire_we or retire_addr; this avoids a combinational loop through decode ready_go.
- Same instruction reading and writing the same register (e.g. addi r4,r4,1): stall is evaluated on counters before its own issue; after issue the counter is 1.
- Latency:
  - A retire at posedge N makes cnt 0, so stall drops during cycle N+1.
  - The regfile write also lands at posedge N, so decode reads the new value in cycle N+1.
  - Minimum load/ALU-use penalty: 3 stall cycles (EXE, MEM, WB).
- busy = OR over all cnt!=0; combinational from registers.
- The counter array is the only state; no FSM beyond the counters.

Optional Feature:
- Macro SB_WB_BYPASS_EN.
- Defined:
  - A source is not blocking if retire_we & retire_addr==src & cnt[src]==1 in the current cycle.
  - Adds outputs src1_wb_fwd and src2_wb_fwd (1 bit each), which assert for a source in exactly that condition. Decode muxes WB data into rj_value/rkd_value when asserted.
  - stall then depends combinationally on retire_* but never on issue_fire.
  - Penalty is reduced to 2 cycles.
- Undefined: the behaviour above; no fwd outputs.

Test Plan:
- Reset: hold resetn=0 2 cycles with random inputs -> stall=0, busy=0, err=0 after release; src1_re=1, src1_addr=5 -> stall=0.
- Single RAW:
  - Issue dest=5 at cycle 0, then src1_addr=5 -> stall=1 cycles 1-3.
  - retire_addr=5 at posedge 3 -> stall=0 in cycle 4; cnt[5]=0, busy=0.
  - With SB_WB_BYPASS_EN: stall=0 in cycle 3 and src1_wb_fwd=1.
- r0 and non-writers: issue_we=1, dest=0; then issue_we=0, dest=7 -> busy stays 0; src2_addr=0 or 7 -> stall=0.
- Double write / same-cycle issue+retire:
  - Issue dest=9 twice -> cnt=2.
  - Issue dest=9 and retire 9 in the same cycle -> cnt stays 2.
  - Two retires -> cnt=0, stall on src 9 clears only after the last retire.
- Overflow/underflow:
  - Four issues to r3 with no retire -> cnt=3, err=1 after the 4th.
  - Reset, then retire r3 with cnt=0 -> cnt=0, err=1.
- Flush: pending r4=2 and r6=1; flush with simultaneous issue dest=8 -> next cycle all counters 0, busy=0, stall=0, err unchanged.
